sram_1r1w_access_ctrl: RTL

- Requester-side controller for the 1R1W synchronous-read SRAM macro (depth 64 × 256 b by default). It drives the macro's R0_*/W0_* ports.
- After reset it scrubs the array to zero. It then accepts independent read and write requests.
- Read data is returned on a ready/valid response channel with full back-pressure. Data is captured so that later writes cannot corrupt a pending response.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_resp_fifo.sv | 55 +++++
 rtl/sram_1r1w_access_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the 1R1W SRAM access controller.
// Holds the controller state encoding and the default macro geometry.
package sram_ctrl_pkg;

  localparam int DEPTH           = 64;
  localparam int WIDTH           = 256;
  localparam int ADDR_W          = $clog2(DEPTH);
  localparam int RESP_FIFO_DEPTH = 2;
  localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small ready/valid FIFO holding read responses; 0-cycle read of head, push and pop in the same cycle.
// A push when full is dropped unless a pop frees the slot in that cycle; the caller keeps occupancy in range.
module sram_resp_fifo #(
  parameter int WIDTH = sram_ctrl_pkg::WIDTH,
  parameter int DEPTH = sram_ctrl_pkg::RESP_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign do_pop    = out_valid && out_ready;
  assign do_push   = in_valid && ((count < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= in_data;
        wptr      <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_1r1w_access_ctrl.sv
// Requester-side controller for a 1R1W synchronous-read SRAM: zero-scrubs after reset, then serves
// independent reads/writes; read response appears the cycle after accept, held in a 2-deep FIFO under back-pressure.
module sram_1r1w_access_ctrl #(
  parameter int DEPTH  = sram_ctrl_pkg::DEPTH,
  parameter int WIDTH  = sram_ctrl_pkg::WIDTH,
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [WIDTH-1:0]  wr_req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data
);

  import sram_ctrl_pkg::state_e;
  import sram_ctrl_pkg::ST_INIT;
  import sram_ctrl_pkg::ST_RUN;
  import sram_ctrl_pkg::RESP_FIFO_DEPTH;
  import sram_ctrl_pkg::RESP_CNT_W;

  state_e                state;
  logic [ADDR_W-1:0]     scrub_ptr;
  logic                  running;
  logic                  inflight;
  logic                  rd_accept;
  logic                  bypass;
  logic                  fifo_push;
  logic                  fifo_valid;
  logic [WIDTH-1:0]      fifo_data;
  logic [RESP_CNT_W-1:0] fifo_count;

  assign running   = (state == ST_RUN);
  assign init_done = running;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      scrub_ptr <= '0;
    end else if (!running) begin
      scrub_ptr <= scrub_ptr + 1'b1;
      if (scrub_ptr == ADDR_W'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Write port: scrub zeros during INIT, then pass requests straight through.
  assign wr_req_ready = running;

  always_comb begin
    W0_en   = 1'b1;
    W0_addr = scrub_ptr;
    W0_data = '0;
    if (running) begin
      W0_en   = wr_req_valid;
      W0_addr = wr_req_addr;
      W0_data = wr_req_data;
    end
  end

  // A read is only issued while a response slot is guaranteed for it.
  assign rd_req_ready = running &&
                        ((int'(fifo_count) + int'(inflight)) < RESP_FIFO_DEPTH);
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign R0_en        = rd_accept;
  assign R0_addr      = rd_req_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_accept;
    end
  end

  // With the FIFO empty, macro data is presented directly so the response
  // appears the cycle after accept; it is still captured at the end of that
  // cycle when not consumed, so a following write cannot alter it.
  assign bypass     = inflight && !fifo_valid;
  assign fifo_push  = inflight && !(bypass && resp_ready);
  assign resp_valid = inflight || fifo_valid;
  assign resp_data  = bypass ? R0_data : fifo_data;

  sram_resp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RESP_FIFO_DEPTH),
    .CNT_W (RESP_CNT_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (fifo_push),
    .in_data   (R0_data),
    .out_valid (fifo_valid),
    .out_ready (resp_ready),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

endmodule
